prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader upstream of the CPU top.
- Accepts a 32-bit word stream over a valid/ready handshake.
- Writes the words through the CPU's external instruction-memory port (addr_ext/wen_ext/wdata_ext), then through its external data-memory port (addr_ext_2/wen_ext_2/wdata_ext_2).
- Drives the CPU enable only after a complete, legal image has been written.

Parameters:
- IMEM_DEPTH, 512, max instruction words accepted.
- DMEM_DEPTH, 1024, max data words accepted.
- ADDR_INC, 4, address increment per word (byte addressing).
- IMEM_BASE, 0, first instruction-memory address.
- DMEM_BASE, 0, first data-memory address.

Ports:
- clk  in  1  main clock
- arst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse that begins a load
- s_valid  in  1  stream word valid
- s_data  in  32  stream word
- s_ready  out  1  loader accepts the word this cycle
- addr_ext  out  32  instruction-memory external address
- wen_ext  out  1  instruction-memory external write enable
- ren_ext  out  1  instruction-memory external read enable; tied 0
- wdata_ext  out  32  instruction-memory external write data
- addr_ext_2  out  32  data-memory external address
- wen_ext_2  out  1  data-memory external write enable
- ren_ext_2  out  1  data-memory external read enable; tied 0
- wdata_ext_2  out  32  data-memory external write data
- cpu_enable  out  1  CPU run enable
- busy  out  1  load in progress
- done  out  1  image loaded; CPU running
- error  out  1  load aborted

Behaviour:
- Clock and reset: one clock, clk. Reset arst_n is synchronous and active-low, sampled on the rising clk edge.
- Reset values: all outputs 0; state IDLE; counters 0.
- Beat transfer: a beat transfers when s_valid and s_ready are both 1 at a rising edge.
- s_ready: 1 in HEADER, LOAD_I, LOAD_D and CHECK; 0 elsewhere. There is no other backpressure.
- State IDLE:
  - start=1 -> HEADER, busy=1.
  - s_valid is ignored.
- State HEADER:
  - Header beat fields: i_cnt = s_data[31:16], d_cnt = s_data[15:0].
  - i_cnt > IMEM_DEPTH or d_cnt > DMEM_DEPTH -> ERROR.
  - Otherwise -> LOAD_I if i_cnt != 0; else LOAD_D if d_cnt != 0; else FINISH.
- State LOAD_I:
  - Each beat produces wen_ext=1 exactly one cycle later, for one cycle, with addr_ext = IMEM_BASE + k*ADDR_INC and wdata_ext = the beat data, where k = beat index (0-based).
  - addr_ext and wdata_ext hold their last values after the write.
  - After the i_cnt-th beat -> LOAD_D if d_cnt != 0; else FINISH.
- State LOAD_D: same rules on the _2 port, base DMEM_BASE, d_cnt beats.
- Write ordering: writes are registered, so the final data write completes in the cycle the FSM enters FINISH. Instruction and data writes are never concurrent.
- Idle cycles: s_valid=0 cycles stall the load indefinitely. No write is issued and the counters hold.
- State FINISH (one cycle) -> DONE.
- State DONE:
  - cpu_enable=1, done=1, busy=0.
  - start=1 -> HEADER: cpu_enable=0 and done=0 from the next cycle (reload).
- State ERROR:
  - error=1, busy=0, cpu_enable=0; no further writes.
  - start=1 -> HEADER and clears error.
- start while busy: ignored.
- Stream words outside a load: dropped, since s_ready=0.
- Reset mid-load:
  - Returns to IDLE on the next edge.
  - Any pending registered write is cancelled: wen_ext=0 and wen_ext_2=0 on that edge.
  - Memory contents already written are left as they are.
- Counter widths: 16-bit beat counters. Address computed as 32-bit base + k*ADDR_INC; wraps modulo 2^32.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data beat (or the header, if both counts are 0), the FSM enters CHECK and accepts one beat.
  - That beat is compared with the 32-bit wraparound sum of all image words, header included.
  - Equal -> FINISH; else -> ERROR.
- Undefined: no CHECK state; the FSM goes directly to FINISH and no extra beat is consumed.

Test Plan:
- Basic load: start, header 0x0003_0002, words A0..A2 then D0,D1 -> writes:
  - instruction memory: addr 0,4,8 with data A0..A2;
  - data memory: addr 0,4 with data D0,D1;
  - cpu_enable=1 two cycles after the D1 beat.
- Overflow header: header 0x0201_0000 (i_cnt 513 > 512) -> error=1 next cycle; no wen_ext; cpu_enable=0.
- Zero counts: header 0x0000_0000 -> no writes; done=1 and cpu_enable=1 within 2 cycles (checksum disabled).
- Stall: s_valid toggled 1,0,0,1 during LOAD_I -> exactly 2 writes at addr 0,4; addresses not skipped or duplicated.
- Reset mid-load: arst_n=0 one cycle after the 2nd instruction beat -> wen_ext=0, state IDLE, all outputs 0. Restart with header 0x0001_0000 loads from addr 0.
- PROG_LOADER_CHECKSUM_EN:
  - header 0x0001_0000 plus word 5, checksum 0x0001_0005 -> done=1;
  - same image with checksum 0x0001_0006 -> error=1, cpu_enable=0.

Source files
------------

// File: rtl/prog_loader_if.sv
// prog_loader_if: word stream into the loader plus the CPU external imem/dmem write ports.
interface prog_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [31:0] wdata_ext_2;
  modport master (
    input  s_valid, s_data,
    output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
  modport slave (
    output s_valid, s_data,
    input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot loader streaming a header-sized image into imem then dmem before enabling the CPU.
// Optional PROG_LOADER_CHECKSUM_EN appends a checksum beat covering header and all image words.
module prog_loader #(
  parameter int unsigned IMEM_DEPTH = 512,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned ADDR_INC   = 4,
  parameter int unsigned IMEM_BASE  = 0,
  parameter int unsigned DMEM_BASE  = 0
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          start,
  prog_loader_if.master m,
  output logic          cpu_enable,
  output logic          busy,
  output logic          done,
  output logic          error
);
  typedef enum logic [2:0] {IDLE, HEADER, LOAD_I, LOAD_D, CHECK, FINISH, DONE, ERROR} state_t;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CHECK;
`else
  localparam state_t TAIL = FINISH;
`endif
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, addr2_q, addr2_d, wdata2_q, wdata2_d;
  logic        wen_q, wen_d, wen2_q, wen2_d;
  logic        s_ready_q, s_ready_d, busy_q, busy_d, run_q, run_d, error_q, error_d;
  logic        beat, over;
  logic [15:0] hdr_i, hdr_d, cnt_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif
  assign beat    = m.s_valid && s_ready_q;
  assign hdr_i   = m.s_data[31:16];
  assign hdr_d   = m.s_data[15:0];
  assign cnt_inc = cnt_q + 16'd1;
  assign over    = 32'(hdr_i) > IMEM_DEPTH || 32'(hdr_d) > DMEM_DEPTH;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i_cnt_d  = i_cnt_q;
    d_cnt_d  = d_cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = 1'b0;
    addr2_d  = addr2_q;
    wdata2_d = wdata2_q;
    wen2_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d    = !beat ? sum_q : state_q == HEADER ? m.s_data : sum_q + m.s_data;
`endif
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d = HEADER;
        cnt_d   = '0;
      end
      HEADER: if (beat) begin
        i_cnt_d = hdr_i;
        d_cnt_d = hdr_d;
        state_d = over ? ERROR : hdr_i != '0 ? LOAD_I : hdr_d != '0 ? LOAD_D : TAIL;
      end
      LOAD_I: if (beat) begin
        wen_d   = 1'b1;
        addr_d  = IMEM_BASE + 32'(cnt_q) * ADDR_INC;
        wdata_d = m.s_data;
        cnt_d   = cnt_inc == i_cnt_q ? '0 : cnt_inc;
        state_d = cnt_inc != i_cnt_q ? LOAD_I : d_cnt_q != '0 ? LOAD_D : TAIL;
      end
      LOAD_D: if (beat) begin
        wen2_d   = 1'b1;
        addr2_d  = DMEM_BASE + 32'(cnt_q) * ADDR_INC;
        wdata2_d = m.s_data;
        cnt_d    = cnt_inc == d_cnt_q ? '0 : cnt_inc;
        state_d  = cnt_inc != d_cnt_q ? LOAD_D : TAIL;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: if (beat) state_d = m.s_data == sum_q ? FINISH : ERROR;
`endif
      FINISH: state_d = DONE;
      default: state_d = IDLE;
    endcase
    s_ready_d = state_d inside {HEADER, LOAD_I, LOAD_D, CHECK};
    busy_d    = state_d inside {HEADER, LOAD_I, LOAD_D, CHECK, FINISH};
    run_d     = state_d == DONE;
    error_d   = state_d == ERROR;
  end
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      addr2_q   <= '0;
      wdata2_q  <= '0;
      wen2_q    <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      run_q     <= 1'b0;
      error_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      addr2_q   <= addr2_d;
      wdata2_q  <= wdata2_d;
      wen2_q    <= wen2_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      run_q     <= run_d;
      error_q   <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end
  assign m.s_ready     = s_ready_q;
  assign m.addr_ext    = addr_q;
  assign m.wen_ext     = wen_q;
  assign m.ren_ext     = 1'b0;
  assign m.wdata_ext   = wdata_q;
  assign m.addr_ext_2  = addr2_q;
  assign m.wen_ext_2   = wen2_q;
  assign m.ren_ext_2   = 1'b0;
  assign m.wdata_ext_2 = wdata2_q;
  assign cpu_enable    = run_q;
  assign done          = run_q;
  assign busy          = busy_q;
  assign error         = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table of image headers plus hand sequences; expected memory writes are queued per beat and popped as the DUT writes.
module tb_prog_loader;
  logic clk = 1'b0;
  logic arst_n, start, cpu_enable, busy, done, error;
  int checks = 0, errors = 0, ki, kd;
  logic [63:0] iq[$], dq[$];
  prog_loader_if m();
  prog_loader dut (.clk(clk), .arst_n(arst_n), .start(start), .m(m),
                   .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error));
  always #5 clk = ~clk;
  typedef struct { logic [31:0] hdr; logic exp_err; } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    logic [63:0] e;
    @(posedge clk);
    #1;
    chk("write overlap", 32'(m.wen_ext & m.wen_ext_2), 0);
    if (m.wen_ext) begin
      if (iq.size() == 0) begin
        checks++; errors++;
        $display("FAIL imem write unexpected: addr %h data %h", m.addr_ext, m.wdata_ext);
      end else begin
        e = iq.pop_front();
        chk("imem addr", m.addr_ext, e[63:32]);
        chk("imem data", m.wdata_ext, e[31:0]);
      end
    end
    if (m.wen_ext_2) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL dmem write unexpected: addr %h data %h", m.addr_ext_2, m.wdata_ext_2);
      end else begin
        e = dq.pop_front();
        chk("dmem addr", m.addr_ext_2, e[63:32]);
        chk("dmem data", m.wdata_ext_2, e[31:0]);
      end
    end
  endtask
  task automatic send(input logic [31:0] w, input int kind);
    int n = 0;
    logic ok;
    if (kind == 1) begin iq.push_back({32'(ki) * 4, w}); ki++; end
    if (kind == 2) begin dq.push_back({32'(kd) * 4, w}); kd++; end
    m.s_valid = 1'b1;
    m.s_data = w;
    do begin
      ok = m.s_ready;
      tick();
      n++;
    end while (!ok && n < 16);
    m.s_valid = 1'b0;
    chk("beat accepted", 32'(ok), 1);
  endtask
  task automatic begin_load();
    ki = 0;
    kd = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start busy", 32'(busy), 1);
    chk("start clears run", 32'({cpu_enable, done, error}), 0);
  endtask
  task automatic finish_img(input logic [31:0] sum);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(sum, 0);
`endif
    chk("cpu_enable in FINISH", 32'(cpu_enable), 0);
    tick();
    chk("cpu_enable", 32'(cpu_enable), 1);
    chk("done", 32'(done), 1);
    chk("busy after done", 32'(busy), 0);
    chk("queues drained", 32'(iq.size() + dq.size()), 0);
  endtask
  task automatic run_vec(input vec_t v);
    logic [31:0] sum = v.hdr;
    logic [31:0] w;
    begin_load();
    send(v.hdr, 0);
    if (v.exp_err) begin
      chk("error", 32'(error), 1);
      chk("cpu_enable on error", 32'(cpu_enable), 0);
      chk("busy on error", 32'(busy), 0);
      tick();
      chk("no writes on error", 32'(iq.size() + dq.size()), 0);
    end else begin
      for (int i = 0; i < int'(v.hdr[31:16]); i++) begin
        w = 32'hA000_0000 + 32'(i);
        sum += w;
        send(w, 1);
      end
      for (int i = 0; i < int'(v.hdr[15:0]); i++) begin
        w = 32'hD000_0000 + 32'(i);
        sum += w;
        send(w, 2);
      end
      finish_img(sum);
    end
  endtask
  initial begin
    vecs[0] = '{32'h0003_0002, 1'b0};
    vecs[1] = '{32'h0201_0000, 1'b1};
    vecs[2] = '{32'h0000_0000, 1'b0};
    vecs[3] = '{32'h0000_0401, 1'b1};
    vecs[4] = '{32'h0000_0001, 1'b0};
    vecs[5] = '{32'h0200_0000, 1'b0};
    vecs[6] = '{32'h0001_0400, 1'b0};
    arst_n = 1'b0;
    start = 1'b0;
    m.s_valid = 1'b0;
    m.s_data = '0;
    repeat (3) tick();
    chk("reset outputs", 32'({cpu_enable, busy, done, error, m.s_ready, m.wen_ext, m.wen_ext_2, m.ren_ext, m.ren_ext_2}), 0);
    chk("reset addr", m.addr_ext | m.addr_ext_2, 0);
    arst_n = 1'b1;
    m.s_valid = 1'b1;
    m.s_data = 32'h0001_0000;
    tick();
    chk("idle drops stream", 32'(m.s_ready | busy), 0);
    m.s_valid = 1'b0;
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    begin_load();
    send(32'h0002_0000, 0);
    send(32'hB000_0000, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("stall keeps busy", 32'(busy), 1);
    send(32'hB000_0001, 1);
    finish_img(32'h0002_0000 + 32'hB000_0000 + 32'hB000_0001);
    begin_load();
    send(32'h0003_0000, 0);
    send(32'hC000_0000, 1);
    send(32'hC000_0001, 1);
    arst_n = 1'b0;
    m.s_valid = 1'b1;
    m.s_data = 32'hC000_0002;
    tick();
    chk("reset cancels write", 32'(m.wen_ext), 0);
    chk("reset mid-load outputs", 32'({cpu_enable, busy, done, error, m.s_ready}), 0);
    chk("reset mid-load addr", m.addr_ext, 0);
    arst_n = 1'b1;
    m.s_valid = 1'b0;
    tick();
    begin_load();
    send(32'h0001_0000, 0);
    send(32'hE000_0000, 1);
    finish_img(32'h0001_0000 + 32'hE000_0000);
`ifdef PROG_LOADER_CHECKSUM_EN
    begin_load();
    send(32'h0001_0000, 0);
    send(32'h0000_0005, 1);
    send(32'h0001_0006, 0);
    chk("bad checksum error", 32'(error), 1);
    chk("bad checksum cpu_enable", 32'(cpu_enable), 0);
    begin_load();
    send(32'h0001_0000, 0);
    send(32'h0000_0005, 1);
    finish_img(32'h0001_0005);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
